// File: rtl/md_unit_if.sv
// Request/response bundle between the issue stage and the multiply/divide unit.
interface md_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;
  logic [4:0]      rd_in;
  logic            busy;
  logic            done;
  logic            RegWEn;
  logic [4:0]      AddrD;
  logic [XLEN-1:0] DataD;

  modport master (
    output start, funct3, rs1_val, rs2_val, rd_in,
    input  busy, done, RegWEn, AddrD, DataD
  );

  modport slave (
    input  start, funct3, rs1_val, rs2_val, rd_in,
    output busy, done, RegWEn, AddrD, DataD
  );
endinterface

// File: rtl/md_unit.sv
// Iterative RV32M multiply/divide unit: 32-cycle shift-add / restoring divide,
// divide-by-zero and signed overflow resolved at acceptance.
module md_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  md_unit_if.slave md
);

  localparam int unsigned PW = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] ONES    = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  state_t state_q, state_d;

  logic [2:0]      f3_q;
  logic [XLEN-1:0] a_q, b_q;
  logic [PW-1:0]   mcand_q, prod_q;
  logic [XLEN-1:0] rem_q, quo_q;
  logic [CW-1:0]   count_q;
  logic            sa_q, sb_q;
  logic            special_q;
  logic [XLEN-1:0] spec_res_q;

  logic            accept_c, a_signed_c, b_signed_c, sa_c, sb_c;
  logic            div_zero_c, ovf_c, special_c;
  logic [XLEN-1:0] abs_a_c, abs_b_c, special_res_c;
  logic [XLEN:0]   sh_c;
  logic            ge_c;
  logic [XLEN-1:0] diff_c;
  logic [PW-1:0]   prod_fix_c;
  logic [XLEN-1:0] quo_fix_c, rem_fix_c, result_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus acceptance-time operand decode.
  always_comb begin
    state_d       = state_q;
    accept_c      = (state_q == IDLE) && md.start;
    a_signed_c    = (md.funct3 == 3'd1) || (md.funct3 == 3'd2) ||
                    (md.funct3 == 3'd4) || (md.funct3 == 3'd6);
    b_signed_c    = (md.funct3 == 3'd1) || (md.funct3 == 3'd4) || (md.funct3 == 3'd6);
    sa_c          = a_signed_c && md.rs1_val[XLEN-1];
    sb_c          = b_signed_c && md.rs2_val[XLEN-1];
    abs_a_c       = sa_c ? (~md.rs1_val + 1'b1) : md.rs1_val;
    abs_b_c       = sb_c ? (~md.rs2_val + 1'b1) : md.rs2_val;
    div_zero_c    = md.funct3[2] && (md.rs2_val == '0);
    ovf_c         = ((md.funct3 == 3'd4) || (md.funct3 == 3'd6)) &&
                    (md.rs1_val == INT_MIN) && (md.rs2_val == ONES);
    special_c     = div_zero_c || ovf_c;
    special_res_c = '0;
    if (div_zero_c)  special_res_c = md.funct3[1] ? md.rs1_val : ONES;
    else if (ovf_c)  special_res_c = md.funct3[1] ? '0 : INT_MIN;

    case (state_q)
      IDLE:    if (accept_c) state_d = special_c ? FIN : CALC;
      CALC:    if (count_q == CW'(XLEN - 1)) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One restoring-divide step on the shifted partial remainder.
  always_comb begin
    sh_c   = {rem_q, a_q[XLEN-1]};
    ge_c   = (sh_c >= {1'b0, b_q});
    diff_c = sh_c[XLEN-1:0] - b_q;
  end

  // Sign correction and word selection for the final result.
  always_comb begin
    prod_fix_c = (sa_q ^ sb_q) ? (~prod_q + 1'b1) : prod_q;
    quo_fix_c  = (sa_q ^ sb_q) ? (~quo_q + 1'b1) : quo_q;
    rem_fix_c  = sa_q ? (~rem_q + 1'b1) : rem_q;
    case (f3_q)
      3'd0:                 result_c = prod_fix_c[XLEN-1:0];
      3'd1, 3'd2, 3'd3:     result_c = prod_fix_c[PW-1:XLEN];
      3'd4, 3'd5:           result_c = quo_fix_c;
      default:              result_c = rem_fix_c;
    endcase
    if (special_q) result_c = spec_res_q;
  end

  // Operand capture and the per-cycle multiply/divide iteration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f3_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      mcand_q    <= '0;
      prod_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      count_q    <= '0;
      sa_q       <= 1'b0;
      sb_q       <= 1'b0;
      special_q  <= 1'b0;
      spec_res_q <= '0;
    end else if (accept_c) begin
      f3_q       <= md.funct3;
      a_q        <= abs_a_c;
      b_q        <= abs_b_c;
      mcand_q    <= {{XLEN{1'b0}}, abs_a_c};
      prod_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      count_q    <= '0;
      sa_q       <= sa_c;
      sb_q       <= sb_c;
      special_q  <= special_c;
      spec_res_q <= special_res_c;
    end else if (state_q == CALC) begin
      count_q <= count_q + 1'b1;
      if (!f3_q[2]) begin
        if (b_q[0]) prod_q <= prod_q + mcand_q;
        mcand_q <= {mcand_q[PW-2:0], 1'b0};
        b_q     <= {1'b0, b_q[XLEN-1:1]};
      end else begin
        rem_q <= ge_c ? diff_c : sh_c[XLEN-1:0];
        quo_q <= {quo_q[XLEN-2:0], ge_c};
        a_q   <= {a_q[XLEN-2:0], 1'b0};
      end
    end
  end

  // Registered status and write-back request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md.busy   <= 1'b0;
      md.done   <= 1'b0;
      md.RegWEn <= 1'b0;
      md.AddrD  <= '0;
      md.DataD  <= '0;
    end else begin
      md.busy   <= (state_q != IDLE);
      md.done   <= (state_q == FIN);
      md.RegWEn <= (state_q == FIN) && (md.AddrD != '0);
      if (accept_c)         md.AddrD <= md.rd_in;
      if (state_q == FIN)   md.DataD <= result_c;
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: latency, results, special cases, busy, reset.
module tb_md_unit;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  md_unit_if #(.XLEN(32)) bus ();

  md_unit #(.XLEN(32)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one request so that it is sampled at the next rising edge.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.funct3  = f;
    bus.rs1_val = a;
    bus.rs2_val = b;
    bus.rd_in   = rd;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Step edges until done, recording latency and outputs; lat=-1 on timeout.
  task automatic wait_done(input int budget, output int lat, output logic [31:0] data,
                           output logic [4:0] addr, output int wen_cnt, output int busy_cnt);
    lat = -1; data = '0; addr = '0; wen_cnt = 0; busy_cnt = 0;
    for (int k = 1; k <= budget; k++) begin
      @(posedge clk);
      #1;
      if (bus.busy === 1'b1)   busy_cnt++;
      if (bus.RegWEn === 1'b1) wen_cnt++;
      if (bus.done === 1'b1) begin
        lat  = k;
        data = bus.DataD;
        addr = bus.AddrD;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_chk++; if (bus.busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_chk++; if (bus.done !== 1'b0)   begin n_fail++; $display("FAIL reset_done got %b want 0", bus.done); end
    n_chk++; if (bus.RegWEn !== 1'b0) begin n_fail++; $display("FAIL reset_wen got %b want 0", bus.RegWEn); end
    n_chk++; if (bus.AddrD !== 5'd0)  begin n_fail++; $display("FAIL reset_addr got %0d want 0", bus.AddrD); end
    n_chk++; if (bus.DataD !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.DataD); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int lat, wen, bsy;
    logic [31:0] d;
    logic [4:0]  a;
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_accept got %b want 0", bus.busy); end
    wait_done(40, lat, d, a, wen, bsy);
    n_chk++; if (lat !== 33)          begin n_fail++; $display("FAIL mul_latency got %0d want 33", lat); end
    n_chk++; if (d !== 32'hFFFFFFEB)  begin n_fail++; $display("FAIL mul_data got %h want ffffffeb", d); end
    n_chk++; if (a !== 5'd5)          begin n_fail++; $display("FAIL mul_addr got %0d want 5", a); end
    n_chk++; if (wen !== 1)           begin n_fail++; $display("FAIL mul_wen_count got %0d want 1", wen); end
    n_chk++; if (bsy !== 33)          begin n_fail++; $display("FAIL mul_busy_count got %0d want 33", bsy); end
    @(posedge clk);
    #1;
    n_chk++; if (bus.done !== 1'b0)   begin n_fail++; $display("FAIL mul_done_pulse got %b want 0", bus.done); end
    n_chk++; if (bus.RegWEn !== 1'b0) begin n_fail++; $display("FAIL mul_wen_pulse got %b want 0", bus.RegWEn); end
    n_chk++; if (bus.busy !== 1'b0)   begin n_fail++; $display("FAIL mul_busy_after got %b want 0", bus.busy); end
    n_chk++; if (bus.DataD !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL mul_data_hold got %h want ffffffeb", bus.DataD); end
  endtask

  task automatic test_mulh();
    int lat, wen, bsy;
    logic [31:0] d;
    logic [4:0]  a;
    logic [2:0]  fv [3];
    logic [31:0] ev [3];
    fv = '{3'd1, 3'd3, 3'd2};
    ev = '{32'h40000000, 32'h40000000, 32'hC0000000};
    for (int i = 0; i < 3; i++) begin
      issue(fv[i], 32'h80000000, 32'h80000000, 5'd6);
      wait_done(40, lat, d, a, wen, bsy);
      n_chk++; if (lat !== 33)  begin n_fail++; $display("FAIL mulh%0d_latency got %0d want 33", i, lat); end
      n_chk++; if (d !== ev[i]) begin n_fail++; $display("FAIL mulh%0d_data got %h want %h", i, d, ev[i]); end
    end
  endtask

  task automatic test_div();
    int lat, wen, bsy;
    logic [31:0] d;
    logic [4:0]  a;
    logic [2:0]  fv [4];
    logic [31:0] av [4];
    logic [31:0] bv [4];
    logic [31:0] ev [4];
    fv = '{3'd4, 3'd6, 3'd5, 3'd7};
    av = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100};
    bv = '{32'd2, 32'd2, 32'd7, 32'd7};
    ev = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2};
    for (int i = 0; i < 4; i++) begin
      issue(fv[i], av[i], bv[i], 5'(10 + i));
      wait_done(40, lat, d, a, wen, bsy);
      n_chk++; if (lat !== 33)       begin n_fail++; $display("FAIL div%0d_latency got %0d want 33", i, lat); end
      n_chk++; if (d !== ev[i])      begin n_fail++; $display("FAIL div%0d_data got %h want %h", i, d, ev[i]); end
      n_chk++; if (a !== 5'(10 + i)) begin n_fail++; $display("FAIL div%0d_addr got %0d want %0d", i, a, 10 + i); end
    end
  endtask

  task automatic test_special();
    int lat, wen, bsy;
    logic [31:0] d;
    logic [4:0]  a;
    logic [2:0]  fv [4];
    logic [31:0] av [4];
    logic [31:0] bv [4];
    logic [31:0] ev [4];
    fv = '{3'd5, 3'd6, 3'd4, 3'd6};
    av = '{32'd55, 32'h12345678, 32'h80000000, 32'h80000000};
    bv = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    ev = '{32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'd0};
    for (int i = 0; i < 4; i++) begin
      issue(fv[i], av[i], bv[i], 5'd20);
      wait_done(40, lat, d, a, wen, bsy);
      n_chk++; if (lat !== 1)   begin n_fail++; $display("FAIL spec%0d_latency got %0d want 1", i, lat); end
      n_chk++; if (d !== ev[i]) begin n_fail++; $display("FAIL spec%0d_data got %h want %h", i, d, ev[i]); end
      n_chk++; if (bsy !== 1)   begin n_fail++; $display("FAIL spec%0d_busy_count got %0d want 1", i, bsy); end
    end
  endtask

  task automatic test_busy_ignore();
    int lat, wen, bsy;
    logic [31:0] d;
    logic [4:0]  a;
    issue(3'd5, 32'd100, 32'd7, 5'd3);
    // Hold a conflicting request and changed operands for the whole operation.
    bus.start   = 1'b1;
    bus.funct3  = 3'd0;
    bus.rs1_val = 32'd9;
    bus.rs2_val = 32'd9;
    bus.rd_in   = 5'd9;
    wait_done(40, lat, d, a, wen, bsy);
    bus.start = 1'b0;
    n_chk++; if (lat !== 33)   begin n_fail++; $display("FAIL busy_ign_latency got %0d want 33", lat); end
    n_chk++; if (d !== 32'd14) begin n_fail++; $display("FAIL busy_ign_data got %h want 0000000e", d); end
    n_chk++; if (a !== 5'd3)   begin n_fail++; $display("FAIL busy_ign_addr got %0d want 3", a); end
    @(posedge clk);
    #1;
    n_chk++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL busy_ign_idle got %b want 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    int lat, wen, bsy;
    logic [31:0] d;
    logic [4:0]  a;
    issue(3'd3, 32'h80000000, 32'h80000000, 5'd1);
    wait_done(40, lat, d, a, wen, bsy);
    n_chk++; if (lat !== 33)         begin n_fail++; $display("FAIL b2b_first_latency got %0d want 33", lat); end
    n_chk++; if (d !== 32'h40000000) begin n_fail++; $display("FAIL b2b_first_data got %h want 40000000", d); end
    // Second request presented during the done cycle.
    bus.start   = 1'b1;
    bus.funct3  = 3'd4;
    bus.rs1_val = 32'hFFFFFFF9;
    bus.rs2_val = 32'd2;
    bus.rd_in   = 5'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(40, lat, d, a, wen, bsy);
    n_chk++; if (lat !== 33)         begin n_fail++; $display("FAIL b2b_second_latency got %0d want 33", lat); end
    n_chk++; if (d !== 32'hFFFFFFFD) begin n_fail++; $display("FAIL b2b_second_data got %h want fffffffd", d); end
    n_chk++; if (a !== 5'd7)         begin n_fail++; $display("FAIL b2b_second_addr got %0d want 7", a); end
  endtask

  task automatic test_rd_zero();
    int lat, wen, bsy;
    logic [31:0] d;
    logic [4:0]  a;
    issue(3'd7, 32'd100, 32'd7, 5'd0);
    wait_done(40, lat, d, a, wen, bsy);
    n_chk++; if (lat !== 33)  begin n_fail++; $display("FAIL rd0_latency got %0d want 33", lat); end
    n_chk++; if (d !== 32'd2) begin n_fail++; $display("FAIL rd0_data got %h want 00000002", d); end
    n_chk++; if (wen !== 0)   begin n_fail++; $display("FAIL rd0_wen_count got %0d want 0", wen); end
  endtask

  task automatic test_reset_mid();
    int lat, wen, bsy, dcnt;
    logic [31:0] d;
    logic [4:0]  a;
    issue(3'd4, 32'hFFFFFFF9, 32'd2, 5'd4);
    repeat (10) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    n_chk++; if (bus.busy !== 1'b0)   begin n_fail++; $display("FAIL rstmid_busy got %b want 0", bus.busy); end
    n_chk++; if (bus.AddrD !== 5'd0)  begin n_fail++; $display("FAIL rstmid_addr got %0d want 0", bus.AddrD); end
    n_chk++; if (bus.DataD !== 32'd0) begin n_fail++; $display("FAIL rstmid_data got %h want 0", bus.DataD); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    wen  = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1)   dcnt++;
      if (bus.RegWEn === 1'b1) wen++;
    end
    n_chk++; if (dcnt !== 0) begin n_fail++; $display("FAIL rstmid_done_count got %0d want 0", dcnt); end
    n_chk++; if (wen !== 0)  begin n_fail++; $display("FAIL rstmid_wen_count got %0d want 0", wen); end
    issue(3'd0, 32'd7, 32'hFFFFFFFD, 5'd5);
    wait_done(40, lat, d, a, wen, bsy);
    n_chk++; if (lat !== 33)         begin n_fail++; $display("FAIL rstmid_new_latency got %0d want 33", lat); end
    n_chk++; if (d !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL rstmid_new_data got %h want ffffffeb", d); end
    n_chk++; if (wen !== 1)          begin n_fail++; $display("FAIL rstmid_new_wen got %0d want 1", wen); end
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    bus.start   = 1'b0;
    bus.funct3  = 3'd0;
    bus.rs1_val = 32'd0;
    bus.rs2_val = 32'd0;
    bus.rd_in   = 5'd0;
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_busy_ignore();
    test_back_to_back();
    test_rd_zero();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
